vector_memory_bank: RTL and testbench
=====================================

# vector_memory_bank

Vector storage bank that sits on the memory side of `control_unit` and serves as the responder for its P/R/X address and write-enable streams. One instance backs each solver vector: it accepts lane-packed words (`no_of_units` elements per word) on a write port and returns them on a registered read port. It tracks which words of the current vector pass have been written and pulses `write_done` when the pass is complete, so the sequencer can stop polling address-wrap conditions.

## Interface
- `no_of_units`, 8, lanes (elements) per memory word
- `element_width`, 32, bits per element
- `number_of_equations_per_cluster`, 19, vector length in elements
- `additional`, `no_of_units-(number_of_equations_per_cluster%no_of_units)`, padding elements (derived)
- `total`, `number_of_equations_per_cluster+additional`, padded length (derived; 24 at defaults)
- `depth`, `total/no_of_units`, words per vector (derived; 3 at defaults)
- `memory_read_address_width`, 20, address bus width

Ports:
- `clk` in 1: single clock, all logic on rising edge
- `reset` in 1: synchronous, active-high
- `write_enable` in 1: commit `write_data` at `write_address` this edge
- `write_address` in `memory_read_address_width`: word index
- `write_data` in `no_of_units*element_width`: lane 0 in bits [31:0]
- `read_enable` in 1: issue read of `read_address`
- `read_address` in `memory_read_address_width`: word index
- `clear_pass` in 1: start a new write pass
- `read_data` out `no_of_units*element_width`: registered read word
- `read_valid` out 1: `read_data` valid this cycle
- `write_done` out 1: one-cycle pulse, pass complete
- `words_written` out `$clog2(depth+1)`: distinct words written this pass
- `addr_error` out 1: sticky, an out-of-range access occurred

## Operation
- Storage: `depth` words × `no_of_units*element_width` bits.
- Reset: all words to 0; `read_data`=0, `read_valid`=0, `write_done`=0, `words_written`=0, `addr_error`=0, pass bitmap cleared. Reset overrides every other input.
- Write: `write_enable` with `write_address` < `depth` commits the word on that edge. Out-of-range write: no storage change, `addr_error`<=1.
- Read: `read_enable` with `read_address` < `depth` loads `read_data` with that word on the next edge and sets `read_valid`<=1. Out-of-range read: `read_data`<=0, `read_valid`<=1, `addr_error`<=1. With no `read_enable`, `read_valid`<=0 and `read_data` holds its value.
- Same-address read and write in the same cycle: write-first. `read_data` returns the new `write_data`.
- Pass tracking: one bitmap bit per word. A valid write to a clear bit sets it and increments `words_written`. A rewrite of a set bit changes only the data.
- Completion: the write that sets the last clear bit drives `write_done`<=1 for exactly one cycle. On that same edge the bitmap clears and `words_written`<=0, which starts the next pass automatically.
- `clear_pass`: clears the bitmap and `words_written`. If `clear_pass` and a valid write occur in the same cycle, the clear applies first and the write counts as the first word of the new pass (`words_written`=1). Stored data is never cleared by `clear_pass`.
- `addr_error` clears only on reset.

## Timing
- Write latency: data is visible to a read issued in the same cycle through bypass; otherwise visible from the next cycle.
- Read latency: exactly 1 cycle, fully pipelined, one read per cycle.
- `write_done` is registered and asserts in the cycle after the completing write edge.
- With `depth`=1, every valid write pulses `write_done`. With back-to-back passes, `write_done` can assert every `depth` cycles.
- Reset in mid-pass: the pass is abandoned, no `write_done`, and contents are zeroed.

## Test plan
- Reset, then read addresses 0, 1, 2 on consecutive cycles -> `read_valid` high on cycles 1-3, `read_data`=0 each time, `addr_error`=0.
- Write 0x…A0/A1/A2 (lane pattern) to addresses 2, 0, 1 -> `words_written` goes 1, 2, then 0; `write_done` pulses once, in the cycle after the address-1 write; reads return the written words.
- Write to address 1 and read address 1 in the same cycle with new data 0xDEAD… -> next-cycle `read_data`=0xDEAD…
- Write address 0 twice, then address 1 -> `words_written`=2, no `write_done`. Assert `clear_pass` together with a write to address 2 -> `words_written`=1.
- Write to address 3 and read address 7 -> storage unchanged, `read_data`=0 with `read_valid`=1, `addr_error` stays 1 until reset.
- Write 2 words, assert `reset`, then write 3 words -> `write_done` pulses only after the third post-reset write, and pre-reset data reads back 0.

Source files
------------

// File: rtl/vector_memory_bank.sv
// Vector storage bank: lane-packed word memory with a registered read port,
// write-first bypass, per-pass write tracking and a sticky address error flag.
module vector_memory_bank #(
    parameter int no_of_units                     = 8,
    parameter int element_width                   = 32,
    parameter int number_of_equations_per_cluster = 19,
    parameter int additional = no_of_units - (number_of_equations_per_cluster % no_of_units),
    parameter int total      = number_of_equations_per_cluster + additional,
    parameter int depth      = total / no_of_units,
    parameter int memory_read_address_width       = 20
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    write_enable,
    input  logic [memory_read_address_width-1:0]    write_address,
    input  logic [no_of_units*element_width-1:0]    write_data,
    input  logic                                    read_enable,
    input  logic [memory_read_address_width-1:0]    read_address,
    input  logic                                    clear_pass,
    output logic [no_of_units*element_width-1:0]    read_data,
    output logic                                    read_valid,
    output logic                                    write_done,
    output logic [$clog2(depth+1)-1:0]              words_written,
    output logic                                    addr_error
);

    localparam int word_w = no_of_units * element_width;
    localparam int idx_w  = (depth > 1) ? $clog2(depth) : 1;
    localparam int cnt_w  = $clog2(depth + 1);
    localparam logic [memory_read_address_width-1:0] depth_addr =
        memory_read_address_width'(depth);
    localparam logic [cnt_w-1:0] last_count = cnt_w'(depth - 1);

    logic [word_w-1:0] mem_q [depth];
    logic [word_w-1:0] mem_d [depth];
    logic [word_w-1:0] read_data_q, read_data_d;
    logic              read_valid_q, read_valid_d;
    logic              write_done_q, write_done_d;
    logic [cnt_w-1:0]  words_written_q, words_written_d;
    logic              addr_error_q, addr_error_d;
    logic [depth-1:0]  pass_map_q, pass_map_d;

    logic              wr_ok;
    logic              rd_ok;
    logic [idx_w-1:0]  wr_idx;
    logic [idx_w-1:0]  rd_idx;
    logic [depth-1:0]  pass_base;
    logic [cnt_w-1:0]  count_base;

    assign wr_ok  = write_enable && (write_address < depth_addr);
    assign rd_ok  = read_enable && (read_address < depth_addr);
    assign wr_idx = write_address[idx_w-1:0];
    assign rd_idx = read_address[idx_w-1:0];

    // Commit an in-range write into the storage array.
    always_comb begin
        for (int i = 0; i < depth; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (wr_ok) begin
            mem_d[wr_idx] = write_data;
        end
    end

    // Read port: write-first bypass on address match, zero word for bad addresses.
    always_comb begin
        read_data_d  = read_data_q;
        read_valid_d = read_enable;
        if (read_enable) begin
            if (!rd_ok) begin
                read_data_d = '0;
            end else if (wr_ok && (write_address == read_address)) begin
                read_data_d = write_data;
            end else begin
                read_data_d = mem_q[rd_idx];
            end
        end
    end

    // Pass tracking: clear_pass acts before the write, the last new word ends the pass.
    always_comb begin
        pass_base       = clear_pass ? '0 : pass_map_q;
        count_base      = clear_pass ? '0 : words_written_q;
        pass_map_d      = pass_base;
        words_written_d = count_base;
        write_done_d    = 1'b0;
        if (wr_ok && !pass_base[wr_idx]) begin
            if (count_base == last_count) begin
                write_done_d    = 1'b1;
                pass_map_d      = '0;
                words_written_d = '0;
            end else begin
                pass_map_d[wr_idx] = 1'b1;
                words_written_d    = count_base + cnt_w'(1);
            end
        end
    end

    // Sticky error flag for any out-of-range read or write.
    always_comb begin
        addr_error_d = addr_error_q
                     | (write_enable && !wr_ok)
                     | (read_enable && !rd_ok);
    end

    // State registers with synchronous reset that zeroes storage and all status.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < depth; i++) begin
                mem_q[i] <= '0;
            end
            read_data_q     <= '0;
            read_valid_q    <= 1'b0;
            write_done_q    <= 1'b0;
            words_written_q <= '0;
            addr_error_q    <= 1'b0;
            pass_map_q      <= '0;
        end else begin
            for (int i = 0; i < depth; i++) begin
                mem_q[i] <= mem_d[i];
            end
            read_data_q     <= read_data_d;
            read_valid_q    <= read_valid_d;
            write_done_q    <= write_done_d;
            words_written_q <= words_written_d;
            addr_error_q    <= addr_error_d;
            pass_map_q      <= pass_map_d;
        end
    end

    assign read_data     = read_data_q;
    assign read_valid    = read_valid_q;
    assign write_done    = write_done_q;
    assign words_written = words_written_q;
    assign addr_error    = addr_error_q;

endmodule

// File: tb/tb_vector_memory_bank.sv
// Scoreboard bench for vector_memory_bank: directed scenarios followed by
// random traffic, checked against a set-based behavioural model.
module tb_vector_memory_bank;

    localparam int W     = 256;
    localparam int AW    = 20;
    localparam int DEPTH = 3;
    localparam int CW    = 2;

    typedef struct {
        bit          rv;
        bit          done;
        int          ww;
        bit          err;
        logic [W-1:0] rdata;
    } status_t;

    logic          clk;
    logic          reset;
    logic          write_enable;
    logic [AW-1:0] write_address;
    logic [W-1:0]  write_data;
    logic          read_enable;
    logic [AW-1:0] read_address;
    logic          clear_pass;
    logic [W-1:0]  read_data;
    logic          read_valid;
    logic          write_done;
    logic [CW-1:0] words_written;
    logic          addr_error;

    int tests_run = 0;
    int tests_failed = 0;

    status_t      status_q[$];
    logic [W-1:0] read_q[$];

    logic [W-1:0] m_mem [DEPTH];
    bit           m_written [DEPTH];
    bit           m_err;
    logic [W-1:0] m_rdata;

    vector_memory_bank dut (
        .clk           (clk),
        .reset         (reset),
        .write_enable  (write_enable),
        .write_address (write_address),
        .write_data    (write_data),
        .read_enable   (read_enable),
        .read_address  (read_address),
        .clear_pass    (clear_pass),
        .read_data     (read_data),
        .read_valid    (read_valid),
        .write_done    (write_done),
        .words_written (words_written),
        .addr_error    (addr_error)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [W-1:0] actual,
                               input logic [W-1:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    function automatic logic [W-1:0] lanePattern(input logic [7:0] tag);
        logic [W-1:0] v;
        for (int lane = 0; lane < 8; lane++) begin
            v[lane*32 +: 32] = {24'(lane), tag};
        end
        return v;
    endfunction

    function automatic logic [W-1:0] randomWord();
        logic [W-1:0] v;
        for (int k = 0; k < 8; k++) begin
            v[k*32 +: 32] = $urandom;
        end
        return v;
    endfunction

    // Drive one cycle of inputs, let the edge happen, then advance the model
    // and queue the expected response for the monitor.
    task automatic applyStimulus(input bit rst, input bit we, input logic [AW-1:0] wa,
                                 input logic [W-1:0] wd, input bit re,
                                 input logic [AW-1:0] ra, input bit clr);
        status_t s;
        bit      wr_ok;
        bit      rd_ok;
        bit      all_set;
        int      cnt;
        reset         = rst;
        write_enable  = we;
        write_address = wa;
        write_data    = wd;
        read_enable   = re;
        read_address  = ra;
        clear_pass    = clr;
        @(posedge clk);
        s.done = 1'b0;
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_mem[i]     = '0;
                m_written[i] = 1'b0;
            end
            m_err   = 1'b0;
            m_rdata = '0;
            s.rv    = 1'b0;
        end else begin
            wr_ok = we && (wa < DEPTH);
            rd_ok = re && (ra < DEPTH);
            if (re) begin
                if (!rd_ok)                     m_rdata = '0;
                else if (wr_ok && (wa == ra))   m_rdata = wd;
                else                            m_rdata = m_mem[ra];
                read_q.push_back(m_rdata);
            end
            if (clr) begin
                for (int i = 0; i < DEPTH; i++) m_written[i] = 1'b0;
            end
            if (wr_ok) begin
                m_mem[wa]     = wd;
                m_written[wa] = 1'b1;
                all_set = 1'b1;
                for (int i = 0; i < DEPTH; i++) all_set &= m_written[i];
                if (all_set) begin
                    s.done = 1'b1;
                    for (int i = 0; i < DEPTH; i++) m_written[i] = 1'b0;
                end
            end
            if ((we && !wr_ok) || (re && !rd_ok)) m_err = 1'b1;
            s.rv = re;
        end
        cnt = 0;
        for (int i = 0; i < DEPTH; i++) cnt += int'(m_written[i]);
        s.ww    = cnt;
        s.err   = m_err;
        s.rdata = m_rdata;
        status_q.push_back(s);
        #1;
    endtask

    task automatic idle();
        applyStimulus(0, 0, '0, '0, 0, '0, 0);
    endtask

    task automatic doWrite(input logic [AW-1:0] wa, input logic [W-1:0] wd);
        applyStimulus(0, 1, wa, wd, 0, '0, 0);
    endtask

    task automatic doRead(input logic [AW-1:0] ra);
        applyStimulus(0, 0, '0, '0, 1, ra, 0);
    endtask

    // Monitor: compares per-cycle status and pops read data whenever read_valid is seen.
    initial begin
        status_t s;
        forever begin
            @(negedge clk);
            if (status_q.size() > 0) begin
                s = status_q.pop_front();
                checkOutput("read_valid", W'(read_valid), W'(s.rv));
                checkOutput("write_done", W'(write_done), W'(s.done));
                checkOutput("words_written", W'(words_written), W'(s.ww));
                checkOutput("addr_error", W'(addr_error), W'(s.err));
                checkOutput("read_data_hold", read_data, s.rdata);
            end
            if (read_valid === 1'b1) begin
                if (read_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("[TB] FAIL read_unexpected: got read_valid 1 expected no pending read");
                end else begin
                    checkOutput("read_data", read_data, read_q.pop_front());
                end
            end
        end
    end

    // Directed scenarios followed by random traffic.
    initial begin
        reset = 1'b1; write_enable = 1'b0; write_address = '0; write_data = '0;
        read_enable = 1'b0; read_address = '0; clear_pass = 1'b0;

        applyStimulus(1, 0, '0, '0, 0, '0, 0);
        applyStimulus(1, 0, '0, '0, 0, '0, 0);

        doRead(0); doRead(1); doRead(2); idle();

        doWrite(2, lanePattern(8'hA2));
        doWrite(0, lanePattern(8'hA0));
        doWrite(1, lanePattern(8'hA1));
        idle();
        doRead(0); doRead(1); doRead(2); idle();

        applyStimulus(0, 1, 1, {8{32'hDEADBEEF}}, 1, 1, 0);
        idle();

        doWrite(0, lanePattern(8'hB0));
        doWrite(0, lanePattern(8'hB1));
        doWrite(1, lanePattern(8'hB2));
        applyStimulus(0, 1, 2, lanePattern(8'hB3), 0, '0, 1);
        idle();

        applyStimulus(0, 1, 3, lanePattern(8'hEE), 1, 7, 0);
        doRead(0); doRead(1); doRead(2); idle(); idle();

        doWrite(0, lanePattern(8'hC0));
        doWrite(1, lanePattern(8'hC1));
        applyStimulus(1, 0, '0, '0, 0, '0, 0);
        doRead(0); doRead(1);
        doWrite(0, lanePattern(8'hD0));
        doWrite(1, lanePattern(8'hD1));
        doWrite(2, lanePattern(8'hD2));
        idle();
        doRead(0); doRead(1); doRead(2); idle();

        for (int n = 0; n < 400; n++) begin
            logic [AW-1:0] wa;
            logic [AW-1:0] ra;
            wa = ($urandom_range(0, 15) < 13) ? AW'($urandom_range(0, DEPTH-1))
                                              : AW'($urandom_range(DEPTH, 9));
            ra = ($urandom_range(0, 15) < 13) ? AW'($urandom_range(0, DEPTH-1))
                                              : AW'($urandom_range(DEPTH, 9));
            applyStimulus($urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1, wa,
                          randomWord(), $urandom_range(0, 1) == 1, ra,
                          $urandom_range(0, 15) == 0);
        end
        idle();

        @(negedge clk);
        #1;
        checkOutput("scoreboard_drain", W'(status_q.size() + read_q.size()), '0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
